// File: rtl/cpu_defs_pkg.sv
// rtl/cpu_defs_pkg.sv - shared fetch types, reset PC and fetch FSM encoding
package cpu_defs_pkg;

  typedef logic [31:0] uint32_t;

  typedef struct packed {
    uint32_t inst;
    uint32_t pc;
    logic    adel;
  } fetch_entry_t;

  localparam uint32_t RESET_PC = 32'hBFC0_0000;

  typedef enum logic [1:0] {
    ST_RUN   = 2'd0,
    ST_DRAIN = 2'd1,
    ST_HALT  = 2'd2
  } fetch_state_e;

  function automatic uint32_t line_base(input uint32_t pc);
    return {pc[31:3], 3'b000};
  endfunction

endpackage

// File: rtl/cpu_ibus_if.sv
// rtl/cpu_ibus_if.sv - fetch-to-I$ read bus; a read completes when read && !stall
interface cpu_ibus_if;
  logic        read;
  logic [31:0] address;
  logic        stall;
  logic [63:0] rddata;

  modport master (output read, output address, input stall, input rddata);
  modport slave  (input read, input address, output stall, output rddata);
endinterface

// File: rtl/inst_fifo.sv
// rtl/inst_fifo.sv - 2-write / 1-read circular buffer of fetch entries with flush
module inst_fifo
  import cpu_defs_pkg::*;
#(
  parameter int DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     flush_i,
  input  logic [1:0]               wr_cnt_i,
  input  fetch_entry_t             wr0_i,
  input  fetch_entry_t             wr1_i,
  input  logic                     rd_i,
  output fetch_entry_t             head_o,
  output logic                     valid_o,
  output logic [$clog2(DEPTH):0]   free_o
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  fetch_entry_t  mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q;
  logic [AW-1:0] rd_ptr_q;
  logic [CW-1:0] count_q;
  logic          do_rd;

  assign do_rd   = rd_i && (count_q != '0);
  assign valid_o = (count_q != '0);
  assign head_o  = mem_q[rd_ptr_q];
  assign free_o  = CW'(DEPTH) - count_q;

  // Storage carries no reset; valid_o alone qualifies the head.
  always_ff @(posedge clk) begin
    if (!flush_i && wr_cnt_i != 2'd0) mem_q[wr_ptr_q] <= wr0_i;
    if (!flush_i && wr_cnt_i == 2'd2) mem_q[wr_ptr_q + AW'(1)] <= wr1_i;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else if (flush_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_q + AW'(wr_cnt_i);
      rd_ptr_q <= rd_ptr_q + AW'(do_rd);
      count_q  <= count_q + CW'(wr_cnt_i) - CW'(do_rd);
    end
  end

  a_no_overflow : assert property (@(posedge clk) disable iff (!rst_n)
    !flush_i |-> (CW'(wr_cnt_i) <= free_o));

endmodule

// File: rtl/ifetch_unit.sv
// rtl/ifetch_unit.sv - fetch PC, 8-byte bus reads, word split and decode queue
// Redirects flush the queue; a redirect under a stalled read drains that read first.
module ifetch_unit
  import cpu_defs_pkg::*;
#(
  parameter logic [31:0] RESET_PC    = cpu_defs_pkg::RESET_PC,
  parameter int          QUEUE_DEPTH = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  cpu_ibus_if.master        ibus,
  input  logic              redirect_valid,
  input  logic [31:0]       redirect_pc,
  output logic              inst_valid,
  output logic [31:0]       inst,
  output logic [31:0]       inst_pc,
  output logic              inst_adel,
  input  logic              inst_ready
);

  localparam int CW = $clog2(QUEUE_DEPTH) + 1;

  fetch_state_e  state_q, state_d;
  uint32_t       pc_q, pc_d;
  uint32_t       addr_q, addr_d;
  logic          read_q, read_d;
  logic          complete;
  logic          pop;
  logic [1:0]    wr_cnt;
  fetch_entry_t  wr0, wr1, head;
  logic          head_valid;
  logic [CW-1:0] free, free_d;

  assign complete = read_q && !ibus.stall;
  assign pop      = head_valid && inst_ready && !redirect_valid;

  always_comb begin
    wr_cnt  = 2'd0;
    wr0     = '0;
    wr1     = '0;
    state_d = state_q;
    pc_d    = pc_q;
    if (redirect_valid) begin
      pc_d    = redirect_pc;
      state_d = (read_q && ibus.stall) ? ST_DRAIN : ST_RUN;
    end else begin
      unique case (state_q)
        ST_RUN: begin
          if (pc_q[1:0] != 2'b00) begin
            wr_cnt  = 2'd1;
            wr0     = '{inst: 32'h0, pc: pc_q, adel: 1'b1};
            state_d = ST_HALT;
          end else if (complete) begin
            if (pc_q[2]) begin
              wr_cnt = 2'd1;
              wr0    = '{inst: ibus.rddata[63:32], pc: pc_q, adel: 1'b0};
            end else begin
              wr_cnt = 2'd2;
              wr0    = '{inst: ibus.rddata[31:0], pc: pc_q, adel: 1'b0};
              wr1    = '{inst: ibus.rddata[63:32], pc: pc_q + 32'd4, adel: 1'b0};
            end
            pc_d = {pc_q[31:3] + 29'd1, 3'b000};
          end
        end
        ST_DRAIN: if (complete) state_d = ST_RUN;
        default: ;
      endcase
    end
    // Issue decision for next cycle uses next cycle's free count, i.e. before its pop.
    free_d = redirect_valid ? CW'(QUEUE_DEPTH) : (free - CW'(wr_cnt) + CW'(pop));
    read_d = (state_d == ST_DRAIN) ||
             (state_d == ST_RUN && pc_d[1:0] == 2'b00 && free_d >= CW'(2));
    addr_d = (state_d == ST_DRAIN) ? addr_q : line_base(pc_d);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_RUN;
      pc_q    <= RESET_PC;
      addr_q  <= '0;
      read_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      addr_q  <= addr_d;
      read_q  <= read_d;
    end
  end

  inst_fifo #(.DEPTH(QUEUE_DEPTH)) u_fifo (
    .clk      (clk),
    .rst_n    (rst_n),
    .flush_i  (redirect_valid),
    .wr_cnt_i (wr_cnt),
    .wr0_i    (wr0),
    .wr1_i    (wr1),
    .rd_i     (pop),
    .head_o   (head),
    .valid_o  (head_valid),
    .free_o   (free)
  );

  assign ibus.read    = read_q;
  assign ibus.address = addr_q;
  assign inst_valid   = head_valid;
  assign inst         = head.inst;
  assign inst_pc      = head.pc;
  assign inst_adel    = head_valid && head.adel;

endmodule

// File: tb/tb_ifetch_unit.sv
// tb/tb_ifetch_unit.sv - self-checking bench for ifetch_unit with I$ model and PC-stream model
module tb_ifetch_unit;
  import cpu_defs_pkg::*;

  localparam logic [31:0] K         = 32'hA5A5_5A5A;
  localparam logic [31:0] EXP_RESET = 32'hBFC0_0000;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_pc = 32'h0;
  logic        inst_ready = 1'b0;
  logic        stall = 1'b0;
  logic        inst_valid, inst_adel;
  logic [31:0] inst, inst_pc;

  always #5 clk = ~clk;

  cpu_ibus_if ibus();
  assign ibus.stall  = stall;
  assign ibus.rddata = {(ibus.address + 32'd4) ^ K, ibus.address ^ K};

  ifetch_unit #(.RESET_PC(32'hBFC0_0000), .QUEUE_DEPTH(8)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .ibus           (ibus),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .inst_valid     (inst_valid),
    .inst           (inst),
    .inst_pc        (inst_pc),
    .inst_adel      (inst_adel),
    .inst_ready     (inst_ready)
  );

  int n_pass = 0;
  int n_total = 0;

  task automatic chk(input bit ok, input string nm, input logic [95:0] act, input logic [95:0] exp);
    n_total++;
    if (ok) n_pass++;
    else $display("FAIL %s: got %h required %h", nm, act, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Expected stream: after reset/redirect to P, pops are P, P+4, ... ; misaligned P gives one adel entry then silence.
  logic [31:0] m_pc;
  int          m_mode;
  bit          prev_hold;
  logic [31:0] prev_addr;
  int          comp_cnt;
  bit          first_v;
  logic [31:0] first_addr;
  int          n_pops = 0;

  always @(negedge clk) begin
    if (!rst_n) begin
      m_pc      = EXP_RESET;
      m_mode    = 0;
      prev_hold = 1'b0;
    end else begin
      if (prev_hold)
        chk(ibus.read && ibus.address == prev_addr, "bus_hold",
            96'({ibus.read, ibus.address}), 96'({1'b1, prev_addr}));
      prev_hold = ibus.read && ibus.stall;
      prev_addr = ibus.address;
      if (m_mode == 2)
        chk(!ibus.read && !inst_valid, "halt_idle", 96'({ibus.read, inst_valid}), 96'(0));
      if (redirect_valid) begin
        m_pc     = redirect_pc;
        m_mode   = (redirect_pc[1:0] != 2'b00) ? 1 : 0;
        comp_cnt = 0;
        first_v  = 1'b0;
      end else begin
        if (ibus.read && !ibus.stall) begin
          if (!first_v) begin
            first_addr = ibus.address;
            first_v    = 1'b1;
          end
          comp_cnt++;
        end
        if (inst_valid && inst_ready) begin
          n_pops++;
          if (m_mode == 1) begin
            chk(inst_adel && inst_pc == m_pc && inst == 32'h0, "pop_adel",
                96'({inst_adel, inst_pc, inst}), 96'({1'b1, m_pc, 32'h0}));
            m_mode = 2;
          end else begin
            chk(!inst_adel && inst_pc == m_pc && inst == (m_pc ^ K), "pop",
                96'({inst_adel, inst_pc, inst}), 96'({1'b0, m_pc, m_pc ^ K}));
            m_pc = m_pc + 32'd4;
          end
        end
      end
    end
  end

  typedef struct {
    logic [31:0] pc;
    logic [31:0] first_addr;
    logic        adel;
    int          reads;
  } vec_t;

  vec_t vecs[6];

  initial begin
    bit          found;
    int          gaps;
    int          base;
    logic [31:0] a_held;
    logic [31:0] r;

    vecs[0] = '{32'h8000_0000, 32'h8000_0000, 1'b0, 4};
    vecs[1] = '{32'h8000_0004, 32'h8000_0000, 1'b0, 4};
    vecs[2] = '{32'h8000_0002, 32'h0,         1'b1, 0};
    vecs[3] = '{32'hFFFF_FFF8, 32'hFFFF_FFF8, 1'b0, 4};
    vecs[4] = '{32'h0000_0003, 32'h0,         1'b1, 0};
    vecs[5] = '{32'hFFFF_FFFC, 32'hFFFF_FFF8, 1'b0, 4};

    // Reset state and straight-line fetch from the reset PC
    inst_ready = 1'b1;
    repeat (3) @(negedge clk);
    chk(!ibus.read, "rst_read", 96'(ibus.read), 96'(0));
    chk(!inst_valid, "rst_valid", 96'(inst_valid), 96'(0));
    chk(!inst_adel, "rst_adel", 96'(inst_adel), 96'(0));
    step();
    rst_n = 1'b1;
    found = 1'b0;
    for (int i = 0; i < 10 && !found; i++) begin
      @(negedge clk);
      if (ibus.read && !ibus.stall) found = 1'b1;
    end
    chk(found, "first_read_timeout", 96'(found), 96'(1));
    chk(ibus.address == EXP_RESET, "first_addr", 96'(ibus.address), 96'(EXP_RESET));
    @(negedge clk);
    chk(inst_valid, "fill_latency", 96'(inst_valid), 96'(1));
    gaps = 0;
    repeat (20) begin
      @(negedge clk);
      if (!inst_valid) gaps++;
    end
    chk(gaps == 0, "no_gaps", 96'(gaps), 96'(0));

    // Reset in the middle of a request
    found = 1'b0;
    for (int i = 0; i < 8 && !found; i++) begin
      step();
      if (ibus.read) found = 1'b1;
    end
    chk(found, "mid_req_timeout", 96'(found), 96'(1));
    #2 rst_n = 1'b0;
    #1;
    chk(!ibus.read && !inst_valid, "reset_drop", 96'({ibus.read, inst_valid}), 96'(0));
    repeat (2) step();
    rst_n = 1'b1;
    repeat (10) step();

    // Redirect table: fill with decode blocked, head contents, then resume
    for (int v = 0; v < 6; v++) begin
      step();
      redirect_valid = 1'b1;
      redirect_pc    = vecs[v].pc;
      inst_ready     = 1'b0;
      stall          = 1'b0;
      step();
      redirect_valid = 1'b0;
      repeat (25) step();
      chk(comp_cnt == vecs[v].reads, "fill_reads", 96'(comp_cnt), 96'(vecs[v].reads));
      if (vecs[v].reads > 0)
        chk(first_addr == vecs[v].first_addr, "redir_addr", 96'(first_addr), 96'(vecs[v].first_addr));
      chk(!ibus.read, "reads_stopped", 96'(ibus.read), 96'(0));
      chk(inst_valid && inst_pc == vecs[v].pc && inst_adel == vecs[v].adel &&
          inst == (vecs[v].adel ? 32'h0 : (vecs[v].pc ^ K)), "head",
          96'({inst_valid, inst_adel, inst_pc, inst}),
          96'({1'b1, vecs[v].adel, vecs[v].pc, vecs[v].adel ? 32'h0 : (vecs[v].pc ^ K)}));
      base = comp_cnt;
      inst_ready = 1'b1;
      repeat (6) step();
      if (vecs[v].reads > 0) chk(comp_cnt > base, "resume", 96'(comp_cnt), 96'(base + 1));
      else chk(comp_cnt == 0, "halt_no_read", 96'(comp_cnt), 96'(0));
      inst_ready = 1'b0;
    end

    // Redirect under a stalled read: address held, data dropped, then fetch at new PC
    step();
    redirect_valid = 1'b1;
    redirect_pc    = 32'h8000_1000;
    inst_ready     = 1'b1;
    step();
    redirect_valid = 1'b0;
    repeat (5) step();
    stall = 1'b1;
    found = 1'b0;
    for (int i = 0; i < 10 && !found; i++) begin
      step();
      if (ibus.read) found = 1'b1;
    end
    chk(found, "stall_read_timeout", 96'(found), 96'(1));
    a_held         = ibus.address;
    redirect_valid = 1'b1;
    redirect_pc    = 32'h9000_0010;
    for (int i = 0; i < 3; i++) begin
      chk(ibus.read && ibus.address == a_held, "drain_hold", 96'({ibus.read, ibus.address}), 96'({1'b1, a_held}));
      step();
      redirect_valid = 1'b0;
    end
    stall = 1'b0;
    chk(ibus.read && ibus.address == a_held, "drain_done", 96'({ibus.read, ibus.address}), 96'({1'b1, a_held}));
    step();
    chk(ibus.read && ibus.address == 32'h9000_0010, "after_drain_addr",
        96'({ibus.read, ibus.address}), 96'({1'b1, 32'h9000_0010}));
    repeat (8) step();

    // Redirect, pop and completion in one cycle
    found = 1'b0;
    for (int i = 0; i < 20 && !found; i++) begin
      step();
      if (ibus.read && inst_valid) found = 1'b1;
    end
    chk(found, "triple_setup", 96'(found), 96'(1));
    redirect_valid = 1'b1;
    redirect_pc    = 32'h8800_000C;
    step();
    redirect_valid = 1'b0;
    chk(!inst_valid, "triple_flush", 96'(inst_valid), 96'(0));
    chk(ibus.read && ibus.address == 32'h8800_0008, "triple_addr",
        96'({ibus.read, ibus.address}), 96'({1'b1, 32'h8800_0008}));
    repeat (10) step();

    // Random traffic against the stream model
    base = n_pops;
    for (int c = 0; c < 1500; c++) begin
      step();
      stall          = ($urandom_range(0, 9) < 3);
      inst_ready     = ($urandom_range(0, 9) < 6);
      redirect_valid = ($urandom_range(0, 29) == 0);
      if (redirect_valid) begin
        r = $urandom;
        case ($urandom_range(0, 5))
          0:       r[1:0] = 2'($urandom_range(1, 3));
          1:       r = 32'hFFFF_FFF0 | (r & 32'h0000_000C);
          default: r[1:0] = 2'b00;
        endcase
        redirect_pc = r;
      end
    end
    step();
    redirect_valid = 1'b0;
    stall          = 1'b0;
    repeat (5) step();
    chk(n_pops - base > 150, "random_progress", 96'(n_pops - base), 96'(151));

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
